// File: rtl/load_store_unit.sv
// Load/store unit: RV32I byte/half/word loads and stores onto a
// single-word memory bus, with optional split of word-crossing
// accesses, a bus-ack timeout and error responses.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_*             request in (valid/ready, store, funct3,
//                     base, 12-bit signed offset, store data)
//   mem_*             word bus (req, we, addr, wstrb, wdata,
//                     ack, rdata)
//   rsp_*             response out (valid/ready, load data,
//                     error code, effective address)
module load_store_unit #(
    parameter int ADDR_W           = 32,
    parameter int ALLOW_MISALIGNED = 0,
    parameter int TIMEOUT_CYCLES   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_base,
    input  logic [11:0]       req_offset,
    input  logic [31:0]       req_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic [1:0]        rsp_err,
    output logic [ADDR_W-1:0] rsp_addr
);

    localparam int CNT_W =
        (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TMO_LAST_I =
        (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_LAST_I);

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_MIS = 2'b01;
    localparam logic [1:0] ERR_TMO = 2'b10;
    localparam logic [1:0] ERR_ILL = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        ACC0,
        ACC1,
        RESP
    } state_t;

    state_t state;
    state_t state_n;

    logic [ADDR_W-1:0] ea;
    logic              store_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rd0_q;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       rsp_data_q;
    logic [1:0]        rsp_err_q;

    // Request decode, evaluated on the incoming request.
    logic [ADDR_W-1:0] ea_calc;
    logic              req_legal;
    logic              req_mis;
    logic [1:0]        req_err;
    logic              accept;

    always_comb begin
        ea_calc = req_base + ADDR_W'($signed(req_offset));
        // Width code 11 never exists; loads also allow the
        // unsigned 1xx forms except 11x, stores only 0xx.
        req_legal = (req_funct3[1:0] != 2'b11) &&
                    (req_store ? !req_funct3[2]
                               : !(req_funct3[2] && req_funct3[1]));
        req_mis = 1'b0;
        unique case (req_funct3[1:0])
            2'b01:   req_mis = ea_calc[0];
            2'b10:   req_mis = |ea_calc[1:0];
            default: req_mis = 1'b0;
        endcase
        if (!req_legal) begin
            req_err = ERR_ILL;
        end else if (req_mis && (ALLOW_MISALIGNED == 0)) begin
            req_err = ERR_MIS;
        end else begin
            req_err = ERR_OK;
        end
    end

    // Access datapath, driven from the registered request.
    logic [1:0]        off;
    logic [2:0]        nbytes;
    logic [3:0]        smask;
    logic [7:0]        lanes;
    logic [63:0]       wshift;
    logic              crosses;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [63:0]       rd_wide;
    logic [31:0]       rd_shift;
    logic [31:0]       ld_data;
    logic              tmo_hit;

    always_comb begin
        off = ea[1:0];
        nbytes = 3'd4;
        smask = 4'b1111;
        unique case (size_q)
            2'b00: begin
                nbytes = 3'd1;
                smask = 4'b0001;
            end
            2'b01: begin
                nbytes = 3'd2;
                smask = 4'b0011;
            end
            default: begin
                nbytes = 3'd4;
                smask = 4'b1111;
            end
        endcase
        // Lanes/data that spill past lane 3 belong to the
        // second (ACC1) word.
        lanes = {4'b0000, smask} << off;
        wshift = {32'h0, wdata_q} << {off, 3'b000};
        crosses = ({1'b0, off} + nbytes) > 3'd4;
        addr0 = {ea[ADDR_W-1:2], 2'b00};
        addr1 = addr0 + ADDR_W'(4);
        // In ACC1 the first word's bytes sit below the second's.
        rd_wide = (state == ACC1) ? {mem_rdata, rd0_q}
                                  : {32'h0, mem_rdata};
        rd_shift = 32'(rd_wide >> {off, 3'b000});
        unique case (size_q)
            2'b00: ld_data = uns_q
                ? {24'h0, rd_shift[7:0]}
                : {{24{rd_shift[7]}}, rd_shift[7:0]};
            2'b01: ld_data = uns_q
                ? {16'h0, rd_shift[15:0]}
                : {{16{rd_shift[15]}}, rd_shift[15:0]};
            default: ld_data = rd_shift;
        endcase
        // mem_ack in the same cycle beats the timeout.
        tmo_hit = (TIMEOUT_CYCLES != 0) &&
                  (cnt == TMO_LAST) && !mem_ack;
    end

    // Next state and outputs.
    always_comb begin
        state_n = state;
        accept = 1'b0;
        req_ready = 1'b0;
        mem_req = 1'b0;
        mem_we = 1'b0;
        mem_addr = '0;
        mem_wstrb = 4'b0000;
        mem_wdata = 32'h0;
        rsp_valid = 1'b0;
        rsp_data = 32'h0;
        rsp_err = ERR_OK;
        rsp_addr = '0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    state_n = (req_err != ERR_OK) ? RESP : ACC0;
                end
            end
            ACC0: begin
                mem_req = 1'b1;
                mem_we = store_q;
                mem_addr = addr0;
                mem_wstrb = lanes[3:0];
                mem_wdata = wshift[31:0];
                if (mem_ack) begin
                    state_n = crosses ? ACC1 : RESP;
                end else if (tmo_hit) begin
                    state_n = RESP;
                end
            end
            ACC1: begin
                mem_req = 1'b1;
                mem_we = store_q;
                mem_addr = addr1;
                mem_wstrb = lanes[7:4];
                mem_wdata = wshift[63:32];
                if (mem_ack || tmo_hit) begin
                    state_n = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_data = rsp_data_q;
                rsp_err = rsp_err_q;
                rsp_addr = ea;
                if (rsp_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ea <= '0;
            store_q <= 1'b0;
            size_q <= 2'b00;
            uns_q <= 1'b0;
            wdata_q <= 32'h0;
            rd0_q <= 32'h0;
            cnt <= '0;
            rsp_data_q <= 32'h0;
            rsp_err_q <= ERR_OK;
        end else begin
            state <= state_n;
            if (accept) begin
                ea <= ea_calc;
                store_q <= req_store;
                size_q <= req_funct3[1:0];
                uns_q <= req_funct3[2];
                wdata_q <= req_wdata;
                cnt <= '0;
                rsp_data_q <= 32'h0;
                rsp_err_q <= req_err;
            end
            if ((state == ACC0) || (state == ACC1)) begin
                if (mem_ack) begin
                    cnt <= '0;
                    if (state == ACC0) begin
                        rd0_q <= mem_rdata;
                    end
                    if (state_n == RESP) begin
                        rsp_data_q <= store_q ? 32'h0 : ld_data;
                    end
                end else if (tmo_hit) begin
                    rsp_err_q <= ERR_TMO;
                    rsp_data_q <= 32'h0;
                end else if (TIMEOUT_CYCLES != 0) begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: one trapping and one
// splitting instance, bus responder plus response scoreboard.
module tb_load_store_unit;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } acc_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  err;
        logic [31:0] addr;
    } rsp_t;

    logic        clk;
    logic        rst;
    logic        sel;
    logic        req_valid;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_base;
    logic [11:0] req_offset;
    logic [31:0] req_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        rsp_ready;
    logic        va;
    logic        vb;

    logic        a_req_ready, b_req_ready;
    logic        a_mem_req, b_mem_req;
    logic        a_mem_we, b_mem_we;
    logic [31:0] a_mem_addr, b_mem_addr;
    logic [3:0]  a_mem_wstrb, b_mem_wstrb;
    logic [31:0] a_mem_wdata, b_mem_wdata;
    logic        a_rsp_valid, b_rsp_valid;
    logic [31:0] a_rsp_data, b_rsp_data;
    logic [1:0]  a_rsp_err, b_rsp_err;
    logic [31:0] a_rsp_addr, b_rsp_addr;

    logic        m_req_ready;
    logic        m_mem_req;
    logic        m_mem_we;
    logic [31:0] m_mem_addr;
    logic [3:0]  m_mem_wstrb;
    logic [31:0] m_mem_wdata;
    logic        m_rsp_valid;
    logic [31:0] m_rsp_data;
    logic [1:0]  m_rsp_err;
    logic [31:0] m_rsp_addr;

    acc_t bus_q[$];
    rsp_t rsp_q[$];
    int   checks = 0;
    int   fails = 0;

    assign va = req_valid & ~sel;
    assign vb = req_valid & sel;

    assign m_req_ready = sel ? b_req_ready : a_req_ready;
    assign m_mem_req   = sel ? b_mem_req   : a_mem_req;
    assign m_mem_we    = sel ? b_mem_we    : a_mem_we;
    assign m_mem_addr  = sel ? b_mem_addr  : a_mem_addr;
    assign m_mem_wstrb = sel ? b_mem_wstrb : a_mem_wstrb;
    assign m_mem_wdata = sel ? b_mem_wdata : a_mem_wdata;
    assign m_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
    assign m_rsp_data  = sel ? b_rsp_data  : a_rsp_data;
    assign m_rsp_err   = sel ? b_rsp_err   : a_rsp_err;
    assign m_rsp_addr  = sel ? b_rsp_addr  : a_rsp_addr;

    load_store_unit #(
        .ADDR_W(32), .ALLOW_MISALIGNED(0), .TIMEOUT_CYCLES(4)
    ) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(va), .req_ready(a_req_ready),
        .req_store(req_store), .req_funct3(req_funct3),
        .req_base(req_base), .req_offset(req_offset),
        .req_wdata(req_wdata),
        .mem_req(a_mem_req), .mem_we(a_mem_we),
        .mem_addr(a_mem_addr), .mem_wstrb(a_mem_wstrb),
        .mem_wdata(a_mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(a_rsp_data), .rsp_err(a_rsp_err),
        .rsp_addr(a_rsp_addr)
    );

    load_store_unit #(
        .ADDR_W(32), .ALLOW_MISALIGNED(1), .TIMEOUT_CYCLES(4)
    ) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(vb), .req_ready(b_req_ready),
        .req_store(req_store), .req_funct3(req_funct3),
        .req_base(req_base), .req_offset(req_offset),
        .req_wdata(req_wdata),
        .mem_req(b_mem_req), .mem_we(b_mem_we),
        .mem_addr(b_mem_addr), .mem_wstrb(b_mem_wstrb),
        .mem_wdata(b_mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(b_rsp_data), .rsp_err(b_rsp_err),
        .rsp_addr(b_rsp_addr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_mem_req"}, 32'(m_mem_req), 32'd0);
        check({tag, "_rsp_valid"}, 32'(m_rsp_valid), 32'd0);
        check({tag, "_req_ready"}, 32'(m_req_ready), 32'd1);
    endtask

    // One full transaction. d0/d1 = cycles of mem_req before
    // mem_ack for each bus access (4 or more means no ack).
    task automatic run(input bit s, input bit st,
                       input logic [2:0] f3,
                       input logic [31:0] base,
                       input logic [11:0] off,
                       input logic [31:0] wd,
                       input int d0, input int d1,
                       input logic [31:0] r0,
                       input logic [31:0] r1,
                       input int hold);
        logic [31:0] ea;
        logic [31:0] w0;
        logic [31:0] a;
        logic [31:0] res;
        logic [1:0]  err;
        int          nb;
        int          nacc;
        int          lane;
        int          k;
        int          d;
        bit          legal;
        bit          tmo;
        acc_t        acc[2];
        acc_t        e;
        rsp_t        r;

        sel = s;
        ea = base + {{20{off[11]}}, off};
        nb = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        legal = st ? (f3 <= 3'd2)
                   : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!legal) err = 2'b11;
        else if (((ea[1:0] & 2'(nb - 1)) != 2'b00) && !s)
            err = 2'b01;
        else err = 2'b00;

        w0 = {ea[31:2], 2'b00};
        a = ea + 32'(nb - 1);
        nacc = ({a[31:2], 2'b00} != w0) ? 2 : 1;
        acc[0] = '{st, w0, 4'b0000, wd << {ea[1:0], 3'b000}};
        acc[1] = '{st, w0 + 32'd4, 4'b0000, 32'h0};
        res = 32'h0;
        for (int i = 0; i < nb; i++) begin
            a = ea + 32'(i);
            lane = int'(a[1:0]);
            k = ({a[31:2], 2'b00} == w0) ? 0 : 1;
            acc[k].strb[lane] = 1'b1;
            if (k == 1) acc[1].wdata[lane*8 +: 8] = wd[i*8 +: 8];
            res[i*8 +: 8] = (k == 1) ? r1[lane*8 +: 8]
                                     : r0[lane*8 +: 8];
        end
        if (nb == 1)
            res = f3[2] ? {24'h0, res[7:0]}
                        : {{24{res[7]}}, res[7:0]};
        else if (nb == 2)
            res = f3[2] ? {16'h0, res[15:0]}
                        : {{16{res[15]}}, res[15:0]};

        tmo = (d0 >= 4) || ((nacc == 2) && (d1 >= 4));
        r.err = (err != 2'b00) ? err : tmo ? 2'b10 : 2'b00;
        r.data = (st || (r.err != 2'b00)) ? 32'h0 : res;
        r.addr = ea;
        rsp_q.push_back(r);
        if (err == 2'b00) begin
            bus_q.push_back(acc[0]);
            if (nacc == 2) bus_q.push_back(acc[1]);
        end

        #1;
        check("req_ready", 32'(m_req_ready), 32'd1);
        req_valid = 1'b1;
        req_store = st;
        req_funct3 = f3;
        req_base = base;
        req_offset = off;
        req_wdata = wd;
        step();
        req_valid = 1'b0;

        for (int j = 0; bus_q.size() > 0; j++) begin
            e = bus_q.pop_front();
            d = (j == 0) ? d0 : d1;
            for (int c = 0; (c <= d) && (c < 4); c++) begin
                check("mem_req", 32'(m_mem_req), 32'd1);
                check("mem_we", 32'(m_mem_we), 32'(e.we));
                check("mem_addr", m_mem_addr, e.addr);
                check("mem_wstrb", 32'(m_mem_wstrb), 32'(e.strb));
                check("mem_wdata", m_mem_wdata, e.wdata);
                if (c == d) begin
                    mem_ack = 1'b1;
                    mem_rdata = (j == 0) ? r0 : r1;
                end
                step();
                mem_ack = 1'b0;
                mem_rdata = 32'h0;
            end
            if (d >= 4) bus_q.delete();
        end

        check("mem_req_drop", 32'(m_mem_req), 32'd0);
        if (rsp_q.size() == 0) begin
            check("rsp_queue", 32'd0, 32'd1);
        end else begin
            r = rsp_q.pop_front();
            for (int h = 0; h <= hold; h++) begin
                check("rsp_valid", 32'(m_rsp_valid), 32'd1);
                check("rsp_data", m_rsp_data, r.data);
                check("rsp_err", 32'(m_rsp_err), 32'(r.err));
                check("rsp_addr", m_rsp_addr, r.addr);
                if (h == hold) rsp_ready = 1'b1;
                step();
                rsp_ready = 1'b0;
            end
        end
        check("rsp_done", 32'(m_rsp_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        sel = 1'b0;
        req_valid = 1'b0;
        req_store = 1'b0;
        req_funct3 = 3'd0;
        req_base = 32'h0;
        req_offset = 12'h0;
        req_wdata = 32'h0;
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        rsp_ready = 1'b0;
        repeat (2) step();

        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check_quiet("rst");
            check("rst_mem_we", 32'(m_mem_we), 32'd0);
            check("rst_mem_addr", m_mem_addr, 32'd0);
            check("rst_mem_wstrb", 32'(m_mem_wstrb), 32'd0);
            check("rst_mem_wdata", m_mem_wdata, 32'd0);
            check("rst_rsp_data", m_rsp_data, 32'd0);
            check("rst_rsp_err", 32'(m_rsp_err), 32'd0);
            check("rst_rsp_addr", m_rsp_addr, 32'd0);
        end
        rst = 1'b0;
        sel = 1'b0;
        step();

        // mem_ack while idle must be ignored
        mem_ack = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        step();
        step();
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        check_quiet("idle_ack");

        // LB with negative offset
        run(0, 0, 3'b000, 32'h100, 12'hFFF, 32'h0,
            0, 0, 32'h80112233, 32'h0, 0);
        // SH in upper half
        run(0, 1, 3'b001, 32'h202, 12'h000, 32'h0000ABCD,
            0, 0, 32'h0, 32'h0, 0);
        // Split LW across words
        run(1, 0, 3'b010, 32'h103, 12'h000, 32'h0,
            0, 0, 32'hAA000000, 32'h00DDCCBB, 0);
        // Same LW trapped
        run(0, 0, 3'b010, 32'h103, 12'h000, 32'h0,
            0, 0, 32'h0, 32'h0, 0);
        // Timeout, then ack on the last allowed cycle
        run(0, 0, 3'b010, 32'h200, 12'h010, 32'h0,
            6, 0, 32'h0, 32'h0, 0);
        run(0, 0, 3'b010, 32'h200, 12'h010, 32'h0,
            3, 0, 32'h12345678, 32'h0, 0);
        // Illegal codes, response held
        run(0, 0, 3'b011, 32'h300, 12'h000, 32'h0,
            0, 0, 32'h0, 32'h0, 3);
        run(0, 1, 3'b100, 32'h300, 12'h004, 32'h55AA55AA,
            0, 0, 32'h0, 32'h0, 3);
        // Half/byte extension variants, delayed acks
        run(0, 0, 3'b101, 32'h1000, 12'h7FE, 32'h0,
            1, 0, 32'h8001FFFF, 32'h0, 1);
        run(0, 0, 3'b001, 32'h1000, 12'h7FE, 32'h0,
            2, 0, 32'h8001FFFF, 32'h0, 0);
        run(0, 0, 3'b100, 32'h41, 12'h000, 32'h0,
            0, 0, 32'h0000F200, 32'h0, 0);
        run(0, 1, 3'b000, 32'h41, 12'h000, 32'h12345678,
            0, 0, 32'h0, 32'h0, 0);
        // Split LH wrapping at top of address space
        run(1, 0, 3'b001, 32'hFFFFFFFF, 12'h000, 32'h0,
            0, 1, 32'h5A000000, 32'h000000C3, 0);
        // Split SW, second access times out
        run(1, 1, 3'b010, 32'h202, 12'h000, 32'h11223344,
            0, 9, 32'h0, 32'h0, 0);
        // Aligned SW on splitting unit
        run(1, 1, 3'b010, 32'h300, 12'h000, 32'hCAFEBABE,
            0, 0, 32'h0, 32'h0, 0);

        // Reset in the middle of an access
        sel = 1'b0;
        #1;
        req_valid = 1'b1;
        req_store = 1'b0;
        req_funct3 = 3'b010;
        req_base = 32'h400;
        req_offset = 12'h0;
        step();
        req_valid = 1'b0;
        check("abort_mem_req", 32'(m_mem_req), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_quiet("abort");
        for (int i = 0; i < 3; i++) begin
            step();
            check("abort_no_rsp", 32'(m_rsp_valid), 32'd0);
        end
        run(0, 0, 3'b010, 32'h400, 12'h000, 32'h0,
            1, 0, 32'hCAFEF00D, 32'h0, 0);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, fails);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: address width, 12 to 32.
REQ-002 SHALL have parameter ALLOW_MISALIGNED, default 0: 0 = trap misaligned accesses; 1 = split word-crossing accesses into two bus accesses.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16: cycles to wait for mem_ack before a bus error; 0 disables the timeout.
REQ-004 SHALL use one clock; reset is synchronous and active-high; ports: clk input 1 (rising-edge clock), rst input 1 (synchronous active-high reset).
REQ-005 SHALL have ports:
  req_valid in 1: request present
  req_ready out 1: unit can accept
  req_store in 1: 1 = store, 0 = load
  req_funct3 in 3: RV32I width code
  req_base in ADDR_W: base register
  req_offset in 12: signed immediate
  req_wdata in 32: store source register
  mem_req out 1: bus access active
  mem_we out 1: bus write
  mem_addr out ADDR_W: word-aligned bus address
  mem_wstrb out 4: byte lane enables
  mem_wdata out 32: lane-aligned write data
  mem_ack in 1: bus access completed
  mem_rdata in 32: read word, valid with mem_ack
  rsp_valid out 1: response present
  rsp_ready in 1: consumer takes response
  rsp_data out 32: extended load result
  rsp_err out 2: 00 ok, 01 misaligned, 10 bus timeout, 11 illegal funct3
  rsp_addr out ADDR_W: effective address

Function
REQ-006 SHALL compute ea = req_base + sign-extended req_offset, modulo 2^ADDR_W, and register it on accept.
REQ-007 SHALL decode loads as 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, and stores as 000 SB, 001 SH, 010 SW; every other code SHALL give rsp_err=11 with no bus access.
REQ-008 SHALL run an FSM with states IDLE, ACC0, ACC1, RESP; req_ready=1 only in IDLE; accept when req_valid&&req_ready.
REQ-009 On accept: if illegal, or (misaligned and ALLOW_MISALIGNED=0), go to RESP with the error code; otherwise go to ACC0. Misaligned means H with ea[0]=1, or W with ea[1:0]!=0.
REQ-010 In ACC0/ACC1, mem_req=1, and mem_we/mem_addr/mem_wstrb/mem_wdata SHALL stay stable until the mem_ack cycle. mem_req SHALL drop the cycle after mem_ack.
REQ-011 ACC0: mem_addr={ea[ADDR_W-1:2],2'b00}; mem_wstrb = size mask (B 0001, H 0011, W 1111) shifted left by ea[1:0], truncated to 4 bits; mem_wdata = req_wdata shifted left by 8*ea[1:0].
REQ-012 An access crosses a word when ea[1:0]+size>4. On mem_ack in ACC0: if it crosses (possible only with ALLOW_MISALIGNED=1), go to ACC1; else go to RESP.
REQ-013 ACC1: mem_addr = ACC0 address + 4, wrapping at 2^ADDR_W; mem_wstrb = the remaining low lanes; mem_wdata = the remaining high source bytes placed from lane 0.
REQ-014 Load result: bytes SHALL be taken from mem_rdata lanes starting at ea[1:0] (ACC0 bytes low, ACC1 bytes high), then sign-extended (LB/LH) or zero-extended (LBU/LHU).
REQ-015 rsp_data SHALL be 0 for stores and for any error.
REQ-016 Timeout: a counter clears on entry to each ACC state and increments each cycle without mem_ack. When it reaches TIMEOUT_CYCLES, the unit SHALL drop mem_req and go to RESP with rsp_err=10. If mem_ack arrives in the same cycle, mem_ack wins.
REQ-017 A timeout in ACC1 SHALL NOT roll back the ACC0 write.
REQ-018 RESP: rsp_valid=1 with rsp_data/rsp_err/rsp_addr held stable until rsp_ready; on rsp_ready go to IDLE.
REQ-019 Minimum latency: accept at cycle N, mem_req at N+1, mem_ack at N+1, rsp_valid at N+2. An error-at-accept gives rsp_valid at N+1.
REQ-020 mem_ack outside ACC states SHALL be ignored.

Reset
REQ-021 rst at a rising edge SHALL force IDLE, clear the counter and ea, and drive mem_req=0, mem_we=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_data=0, rsp_err=00, rsp_addr=0, and req_ready=1 from the next cycle.
REQ-022 rst SHALL take effect in any state, including mid-access. The bus SHALL see mem_req=0 the cycle after reset; no response SHALL be issued for the aborted request.

Verification
REQ-023 LB, base=0x100, offset=-1 (0xFFF), ack next cycle with rdata=0x80112233 -> mem_addr=0xFC, rsp_data=0xFFFFFF80, rsp_err=00, rsp_addr=0xFF.
REQ-024 SH, base=0x202, wdata=0x0000ABCD -> mem_we=1, mem_addr=0x200, mem_wstrb=1100, mem_wdata=0xABCD0000, rsp_err=00, rsp_data=0.
REQ-025 ALLOW_MISALIGNED=1, LW ea=0x103, first rdata=0xAA000000, second rdata=0x00DDCCBB -> accesses at 0x100 then 0x104, rsp_data=0xDDCCBBAA. With ALLOW_MISALIGNED=0 -> rsp_err=01 and no mem_req.
REQ-026 TIMEOUT_CYCLES=4, mem_ack held 0 -> mem_req high 4 cycles, then rsp_err=10; mem_ack on the 4th cycle -> rsp_err=00.
REQ-027 funct3=011 load, and a store with funct3=100 -> rsp_err=11, no bus access; rsp_valid held 3 cycles while rsp_ready=0 with stable outputs.
REQ-028 rst asserted in ACC0 with mem_req high -> mem_req=0 and req_ready=1 next cycle, no rsp_valid; a new LW then completes normally.
